// File: rtl/bsg_rotate_shift_pipelined.sv
// bsg_rotate_shift_pipelined: barrel rotator/shifter with its log2(width) levels spread over
// pipe_stages_p register stages, valid/ready on the input and valid/yumi on the output
module bsg_rotate_shift_pipelined #(
    parameter  int width_p       = 16,
    parameter  int pipe_stages_p = 2,
    localparam int lg_width_lp   = $clog2(width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     data_i,
    input  logic [lg_width_lp-1:0] amt_i,
    input  logic [1:0]             op_i,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    input  logic                   yumi_i,
    output logic                   empty_o
);
    localparam int last_lp = pipe_stages_p - 1;

    // One level: op[1] selects shift (op[0] chooses sign fill), else rotate (op[0] = left)
    function automatic logic [width_p-1:0] step(logic [width_p-1:0] x, logic [1:0] op, int s);
        return op[1] ? (x >> s) | ({width_p{op[0] & x[width_p-1]}} << (width_p - s))
                     : op[0] ? (x << s) | (x >> (width_p - s))
                             : (x >> s) | (x << (width_p - s));
    endfunction

    logic [width_p-1:0]       d   [pipe_stages_p];
    logic [lg_width_lp-1:0]   a   [pipe_stages_p];
    logic [1:0]               o   [pipe_stages_p];
    logic                     vin [pipe_stages_p];
    logic [width_p-1:0]       q   [pipe_stages_p];
    logic [pipe_stages_p-1:0] v;
    logic [pipe_stages_p-1:0] rdy;

    assign d[0]   = data_i;
    assign a[0]   = amt_i;
    assign o[0]   = op_i;
    assign vin[0] = v_i;

    for (genvar k = 0; k < pipe_stages_p; k++) begin : g_stage
        logic [width_p-1:0] t;
        logic [width_p-1:0] qr;
        logic               vr;
        always_comb begin
            t = d[k];
            for (int i = 0; i < lg_width_lp; i++)
                if (i * pipe_stages_p / lg_width_lp == k && a[k][i]) t = step(t, o[k], 1 << i);
        end
        // A stage can move iff some stage at or after it is empty, or the output is taken
        assign rdy[k] = yumi_i | ~&v[last_lp:k];
        always_ff @(posedge clk_i)
            if (!reset_n_i) begin
                vr <= 1'b0;
                qr <= '0;
            end else if (rdy[k]) begin
                vr <= vin[k];
                if (vin[k]) qr <= t;
            end
        assign v[k] = vr;
        assign q[k] = qr;
        if (k < last_lp) begin : g_fwd
            logic [lg_width_lp-1:0] ar;
            logic [1:0]             opr;
            always_ff @(posedge clk_i)
                if (!reset_n_i) begin
                    ar  <= '0;
                    opr <= '0;
                end else if (rdy[k] & vin[k]) begin
                    ar  <= a[k];
                    opr <= o[k];
                end
            assign d[k+1]   = qr;
            assign a[k+1]   = ar;
            assign o[k+1]   = opr;
            assign vin[k+1] = vr;
        end
    end

    assign ready_o = ~reset_n_i | rdy[0];
    assign v_o     = v[last_lp];
    assign data_o  = q[last_lp];
    assign empty_o = ~|v;

    assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
endmodule

// File: tb/tb_bsg_rotate_shift_pipelined.sv
// tb_bsg_rotate_shift_pipelined: directed vectors and stall sequences on a 16/2 instance,
// plus randomized scoreboard runs over width 16/64 and 1..4 stages
module tb_bsg_rotate_shift_pipelined;
    typedef struct {
        logic [15:0] d;
        logic [3:0]  amt;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;
    typedef struct {
        logic [63:0] r;
        int          c;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, v_i, ready, v_o, yumi, empty;
    logic [15:0] d, dout;
    logic [3:0]  amt;
    logic [1:0]  op;
    logic        sw_rst_n, sweep_go;
    int          checks = 0, errors = 0, sw_fin = 0;

    always #5 clk = ~clk;

    bsg_rotate_shift_pipelined #(.width_p(16), .pipe_stages_p(2)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .ready_o(ready), .data_i(d), .amt_i(amt),
        .op_i(op), .v_o(v_o), .data_o(dout), .yumi_i(yumi), .empty_o(empty)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference built directly from the {d,d} rotate definition and explicit sign fill
    function automatic logic [63:0] model(logic [63:0] x, int n, logic [1:0] f, int w);
        logic [63:0]  m;
        logic [127:0] dd;
        m  = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
        x  = x & m;
        dd = ({64'd0, x} << w) | {64'd0, x};
        case (f)
            2'd0:    return 64'(dd >> n) & m;
            2'd1:    return 64'((dd << n) >> w) & m;
            2'd2:    return x >> n;
            default: return (x >> n) | (x[w-1] ? (m & ~(m >> n)) : 64'd0);
        endcase
    endfunction

    for (genvar g = 0; g < 8; g++) begin : g_sw
        localparam int W = g < 4 ? 16 : 64;
        localparam int P = g % 4 + 1;
        localparam int L = $clog2(W);
        logic         sv, sr, svo, sy, se;
        logic [W-1:0] sd, sdo;
        logic [L-1:0] sa;
        logic [1:0]   so;
        ent_t         sq[$];
        bsg_rotate_shift_pipelined #(.width_p(W), .pipe_stages_p(P)) u (
            .clk_i(clk), .reset_n_i(sw_rst_n), .v_i(sv), .ready_o(sr), .data_i(sd), .amt_i(sa),
            .op_i(so), .v_o(svo), .data_o(sdo), .yumi_i(sy), .empty_o(se)
        );
        initial begin
            sv = 1'b0; sy = 1'b0; sd = '0; sa = '0; so = '0;
            wait (sweep_go);
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                sy = svo && (c < 300 || $urandom_range(0, 2) != 0);
                sv = c < 560 && $urandom_range(0, 3) != 0;
                sd = W'({$urandom, $urandom});
                sa = L'($urandom);
                so = 2'($urandom);
                #1;
                if (svo) begin
                    chk("sweep_q", 64'(sq.size() > 0), 64'd1);
                    if (sq.size() > 0) begin
                        chk("sweep_data", 64'(sdo), sq[0].r);
                        if (c < 300) chk("sweep_lat", 64'(c - sq[0].c), 64'(P));
                        if (sy) void'(sq.pop_front());
                    end
                end
                if (sv && sr) sq.push_back('{model(64'(sd), int'(sa), so, W), c});
            end
            chk("sweep_drain", 64'(sq.size()), 64'd0);
            chk("sweep_empty", 64'(se), 64'd1);
            sw_fin++;
        end
    end

    vec_t        tbl[14];
    logic [15:0] q16[$];
    logic [15:0] sw[4];
    logic [1:0]  sop[4];

    initial begin
        tbl = '{'{16'h1234, 4'd4, 2'd0, 16'h4123}, '{16'h8001, 4'd1, 2'd1, 16'h0003},
                '{16'h8000, 4'd15, 2'd2, 16'h0001}, '{16'h8000, 4'd15, 2'd3, 16'hFFFF},
                '{16'h4000, 4'd14, 2'd3, 16'h0001}, '{16'hA5C3, 4'd0, 2'd0, 16'hA5C3},
                '{16'hA5C3, 4'd0, 2'd1, 16'hA5C3}, '{16'hA5C3, 4'd0, 2'd2, 16'hA5C3},
                '{16'hA5C3, 4'd0, 2'd3, 16'hA5C3}, '{16'h0001, 4'd1, 2'd0, 16'h8000},
                '{16'h8000, 4'd15, 2'd1, 16'h4000}, '{16'hF0F0, 4'd4, 2'd2, 16'h0F0F},
                '{16'hF0F0, 4'd4, 2'd3, 16'hFF0F}, '{16'h1234, 4'd4, 2'd1, 16'h2341}};
        sw  = '{16'h0011, 16'h8000, 16'h1234, 16'hF00F};
        sop = '{2'd0, 2'd1, 2'd2, 2'd3};
        rst_n = 1'b0; v_i = 1'b0; yumi = 1'b0; d = '0; amt = '0; op = '0;
        sw_rst_n = 1'b0; sweep_go = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_v_o", 64'(v_o), 64'd0);
        chk("rst_data", 64'(dout), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ready", 64'(ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            v_i = 1'b1; d = tbl[i].d; amt = tbl[i].amt; op = tbl[i].op;
            #1 chk("vec_ready", 64'(ready), 64'd1);
            @(posedge clk); #1 v_i = 1'b0;
            @(negedge clk); #1 chk("vec_early_v_o", 64'(v_o), 64'd0);
            @(negedge clk);
            yumi = v_o;
            #1;
            chk("vec_v_o", 64'(v_o), 64'd1);
            chk("vec_data", 64'(dout), 64'(tbl[i].exp));
            @(posedge clk); #1 yumi = 1'b0;
        end

        amt = 4'd3;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            v_i = 1'b1; d = sw[j]; op = sop[j];
            #1 chk(j < 2 ? "stall_accept" : "stall_ready", 64'(ready), j < 2 ? 64'd1 : 64'd0);
            if (j < 2) @(posedge clk);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            yumi = v_o;
            v_i = j < 2;
            if (j < 2) begin d = sw[j+2]; op = sop[j+2]; end
            #1;
            if (j < 2) chk("drain_ready", 64'(ready), 64'd1);
            chk("drain_v_o", 64'(v_o), 64'd1);
            chk("drain_data", 64'(dout), model(64'(sw[j]), 3, sop[j], 16));
        end
        @(negedge clk);
        yumi = 1'b0; v_i = 1'b0;
        #1;
        chk("drain_done_v_o", 64'(v_o), 64'd0);
        chk("drain_done_empty", 64'(empty), 64'd1);

        for (int c = 0; c < 104; c++) begin
            @(negedge clk);
            v_i = c < 100; d = 16'($urandom); amt = 4'($urandom); op = 2'($urandom);
            yumi = v_o;
            #1;
            if (c >= 2 && c < 102) chk("stream_v_o", 64'(v_o), 64'd1);
            if (c >= 1 && c < 102) chk("stream_empty", 64'(empty), 64'd0);
            if (v_o) begin
                chk("stream_q", 64'(q16.size() > 0), 64'd1);
                if (q16.size() > 0) chk("stream_data", 64'(dout), 64'(q16.pop_front()));
            end
            if (v_i) begin
                chk("stream_ready", 64'(ready), 64'd1);
                if (ready) q16.push_back(16'(model(64'(d), int'(amt), op, 16)));
            end
        end
        chk("stream_drain", 64'(q16.size()), 64'd0);
        yumi = 1'b0;

        @(negedge clk); v_i = 1'b1; d = 16'h1234; amt = 4'd4; op = 2'd0;
        @(negedge clk); d = 16'h5678;
        @(negedge clk); rst_n = 1'b0;
        #1 chk("rst_hold_ready", 64'(ready), 64'd1);
        @(negedge clk); #1;
        chk("rst_fly_v_o", 64'(v_o), 64'd0);
        chk("rst_fly_data", 64'(dout), 64'd0);
        chk("rst_fly_empty", 64'(empty), 64'd1);
        @(negedge clk); rst_n = 1'b1; v_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("post_rst_v_o", 64'(v_o), 64'd0);
            chk("post_rst_empty", 64'(empty), 64'd1);
        end

        @(negedge clk); sw_rst_n = 1'b1; sweep_go = 1'b1;
        for (int t = 0; t < 5000 && sw_fin < 8; t++) @(posedge clk);
        chk("sweep_finished", 64'(sw_fin), 64'd8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
